// File: rtl/msk_tx_pulse_gen.sv
// -----------------------------------------------------------------------------
// msk_tx_pulse_gen
//   MSK baseband pulse shaper. Each accepted data bit becomes a half-sine pulse
//   spanning two bit periods (2*OVERSAMPLE_FACTOR samples). Successive bits
//   alternate between the I and Q channels, so the two channels overlap by one
//   bit period and the output keeps a constant envelope.
//
// Parameters
//   OVERSAMPLE_FACTOR : samples per bit period (2..256)
//   AMPLITUDE         : half-sine peak value (1..32767)
//
// Ports
//   clk          : clock, one output sample per cycle
//   reset        : asynchronous, active-high reset
//   bit_in       : data bit, 1 = positive pulse, 0 = negative pulse
//   bit_valid    : bit_in is valid
//   bit_ready    : bit is accepted on an edge where bit_valid && bit_ready
//   I_out/Q_out  : registered signed baseband samples
//   sample_valid : I_out/Q_out carry a burst sample
//   symbol_start : first sample of each bit period
// -----------------------------------------------------------------------------
module msk_tx_pulse_gen #(
  parameter int OVERSAMPLE_FACTOR = 20,
  parameter int AMPLITUDE         = 16383
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               bit_in,
  input  logic               bit_valid,
  output logic               bit_ready,
  output logic signed [15:0] I_out,
  output logic signed [15:0] Q_out,
  output logic               sample_valid,
  output logic               symbol_start
);

  localparam int  N  = OVERSAMPLE_FACTOR;
  localparam int  CW = $clog2(N);
  localparam int  IW = $clog2(2 * N);
  localparam real PI = 3.14159265358979323846;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  // Half-sine table entry, evaluated at elaboration only.
  function automatic logic [15:0] rom_entry(input int n);
    real x;
    x = real'(AMPLITUDE) * $sin(PI * real'(n) / (2.0 * real'(N)));
    return 16'($rtoi(x + 0.5));
  endfunction

  logic [15:0] rom [2*N];

  for (genvar n = 0; n < 2 * N; n++) begin : g_rom
    localparam logic [15:0] ROM_VAL = rom_entry(n);
    assign rom[n] = ROM_VAL;
  end

  // Current bit: the pulse in its first bit period (or draining in DRAIN).
  // Previous bit: the pulse in its second bit period on the opposite channel.
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ch_q, ch_d;              // channel of current bit, 0 = I
  logic            sign_q, sign_d;          // 1 = positive pulse
  logic            prev_sign_q, prev_sign_d;
  logic            prev_act_q, prev_act_d;  // previous pulse still overlapping
  logic            last;

  assign last = (cnt_q == CW'(N - 1));

  // NOTE: every output of a combinational block gets a default first so that
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ch_d        = ch_q;
    sign_d      = sign_q;
    prev_sign_d = prev_sign_q;
    prev_act_d  = prev_act_q;
    bit_ready   = 1'b0;
    case (state_q)
      IDLE: begin
        bit_ready = 1'b1;
        if (bit_valid) begin
          state_d    = RUN;
          cnt_d      = '0;
          ch_d       = 1'b0;
          sign_d     = bit_in;
          prev_act_d = 1'b0;
        end
      end
      RUN: begin
        bit_ready = last;
        if (last) begin
          cnt_d = '0;
          if (bit_valid) begin
            prev_sign_d = sign_q;
            prev_act_d  = 1'b1;
            ch_d        = ~ch_q;
            sign_d      = bit_in;
          end else begin
            state_d = DRAIN;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (last) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output samples are computed from the next-state values so that the
  // registered outputs line up with the state they describe: an IDLE
  // transfer shows its phase-0 sample right after the accepting edge.
  logic [IW-1:0]      cur_idx, prev_idx;
  logic signed [15:0] cur_pos, prev_pos, cur_val, prev_val;
  logic signed [15:0] i_d, q_d;

  always_comb begin
    cur_idx  = (state_d == DRAIN) ? IW'(N) + IW'(cnt_d) : IW'(cnt_d);
    prev_idx = IW'(N) + IW'(cnt_d);
    cur_pos  = $signed(rom[cur_idx]);
    prev_pos = $signed(rom[prev_idx]);
    cur_val  = sign_d ? cur_pos : -cur_pos;
    prev_val = '0;
    if (state_d == RUN && prev_act_d)
      prev_val = prev_sign_d ? prev_pos : -prev_pos;
    i_d = '0;
    q_d = '0;
    if (state_d != IDLE) begin
      i_d = ch_d ? prev_val : cur_val;
      q_d = ch_d ? cur_val  : prev_val;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ch_q         <= 1'b0;
      sign_q       <= 1'b0;
      prev_sign_q  <= 1'b0;
      prev_act_q   <= 1'b0;
      I_out        <= '0;
      Q_out        <= '0;
      sample_valid <= 1'b0;
      symbol_start <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ch_q         <= ch_d;
      sign_q       <= sign_d;
      prev_sign_q  <= prev_sign_d;
      prev_act_q   <= prev_act_d;
      I_out        <= i_d;
      Q_out        <= q_d;
      sample_valid <= (state_d != IDLE);
      symbol_start <= (state_d != IDLE) && (cnt_d == '0);
    end
  end

endmodule

// File: tb/tb_msk_tx_pulse_gen.sv
// -----------------------------------------------------------------------------
// tb_msk_tx_pulse_gen
//   Directed bench for msk_tx_pulse_gen with OVERSAMPLE_FACTOR=4,
//   AMPLITUDE=16384. At each accepting edge of a burst's first bit the
//   expected per-cycle outputs of the whole burst are pushed to a scoreboard
//   queue; a monitor on the falling edge pops and compares them.
// -----------------------------------------------------------------------------
module tb_msk_tx_pulse_gen;

  localparam int N = 4;
  localparam int A = 16384;

  logic               clk;
  logic               reset;
  logic               bit_in;
  logic               bit_valid;
  logic               bit_ready;
  logic signed [15:0] I_out;
  logic signed [15:0] Q_out;
  logic               sample_valid;
  logic               symbol_start;

  msk_tx_pulse_gen #(
    .OVERSAMPLE_FACTOR(N),
    .AMPLITUDE        (A)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bit_in      (bit_in),
    .bit_valid   (bit_valid),
    .bit_ready   (bit_ready),
    .I_out       (I_out),
    .Q_out       (Q_out),
    .sample_valid(sample_valid),
    .symbol_start(symbol_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int i;
    int q;
    int sv;
    int ss;
    int rdy;
    int env;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   rom_t [2*N] = '{0, 6270, 11585, 15137, 16384, 15137, 11585, 6270};

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    total++;
    bad++;
    $display("FAIL %s observed=timeout expected=event", tag);
  endtask

  // Expected outputs of a burst of n bits sent back to back: bit k starts at
  // sample 4k on channel I (even k) or Q (odd k) and lasts 8 samples.
  task automatic push_burst(input bit bits[8], input int n, input int maxlen,
                            input int env_lo, input int env_hi);
    exp_t e;
    int   len;
    int   v;
    len = 4 * n + 4;
    for (int t = 0; t < len && t < maxlen; t++) begin
      e.i = 0;
      e.q = 0;
      for (int k = 0; k < n; k++) begin
        if (t >= 4 * k && t < 4 * k + 8) begin
          v = bits[k] ? rom_t[t-4*k] : -rom_t[t-4*k];
          if (k % 2 == 0) e.i += v;
          else            e.q += v;
        end
      end
      e.sv  = 1;
      e.ss  = (t % 4 == 0) ? 1 : 0;
      e.rdy = (t % 4 == 3 && t < 4 * n) ? 1 : 0;
      e.env = (t >= env_lo && t <= env_hi) ? 1 : 0;
      sb.push_back(e);
    end
    if (maxlen >= len) begin
      e = '{i: 0, q: 0, sv: 0, ss: 0, rdy: 1, env: 0};
      sb.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    exp_t   e;
    longint p;
    longint d;
    if (sb.size() > 0 && !reset) begin
      e = sb.pop_front();
      check("I_out", int'(I_out), e.i);
      check("Q_out", int'(Q_out), e.q);
      check("sample_valid", int'(sample_valid), e.sv);
      check("symbol_start", int'(symbol_start), e.ss);
      check("bit_ready", int'(bit_ready), e.rdy);
      if (e.env == 1) begin
        p = longint'(I_out) * longint'(I_out) + longint'(Q_out) * longint'(Q_out);
        d = p - longint'(A) * longint'(A);
        if (d < 0) d = -d;
        check("envelope_in_tol", (d <= 2 * A) ? 1 : 0, 1);
      end
    end
  end

  task automatic wait_accept();
    int c;
    c = 0;
    @(negedge clk);
    while (!bit_ready && c < 50) begin
      @(negedge clk);
      c++;
    end
    if (!bit_ready) timeout_fail("wait_ready");
    @(posedge clk);
  endtask

  task automatic send_bits(input bit bits[8], input int n, input int maxlen,
                           input int env_lo, input int env_hi);
    for (int k = 0; k < n; k++) begin
      bit_in    = bits[k];
      bit_valid = 1'b1;
      wait_accept();
      if (k == 0) push_burst(bits, n, maxlen, env_lo, env_hi);
      #1;
    end
    bit_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int c;
    c = 0;
    while (sb.size() > 0 && c < 200) begin
      @(negedge clk);
      c++;
    end
    if (sb.size() > 0) begin
      timeout_fail(tag);
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  bit bits[8];

  initial begin
    reset     = 1'b1;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_I_out", int'(I_out), 0);
    check("rst_Q_out", int'(Q_out), 0);
    check("rst_sample_valid", int'(sample_valid), 0);
    check("rst_symbol_start", int'(symbol_start), 0);
    reset = 1'b0;
    #1;
    check("rst_release_ready", int'(bit_ready), 1);
    @(posedge clk);
    #1;

    // Single positive bit from IDLE.
    bits = '{1, 0, 0, 0, 0, 0, 0, 0};
    send_bits(bits, 1, 100, -1, -1);
    wait_drain("single_bit");

    // Two positive bits: second pulse on Q.
    bits = '{1, 1, 0, 0, 0, 0, 0, 0};
    send_bits(bits, 2, 100, -1, -1);
    wait_drain("two_bits");

    // Bits 0,1,0 with envelope check over samples 5..12.
    bits = '{0, 1, 0, 0, 0, 0, 0, 0};
    send_bits(bits, 3, 100, 4, 11);
    wait_drain("three_bits");

    // Six back-to-back bits.
    bits = '{1, 0, 0, 1, 1, 0, 0, 0};
    send_bits(bits, 6, 100, -1, -1);
    wait_drain("six_bits");

    // Valid rises one cycle after the ready window: DRAIN, one IDLE cycle,
    // then a new burst on I.
    bits = '{1, 0, 0, 0, 0, 0, 0, 0};
    send_bits(bits, 1, 100, -1, -1);
    repeat (4) @(posedge clk);
    #1;
    bits = '{0, 0, 0, 0, 0, 0, 0, 0};
    send_bits(bits, 1, 100, -1, -1);
    wait_drain("late_valid");

    // Reset in the sixth cycle of a burst.
    bits = '{1, 1, 0, 0, 0, 0, 0, 0};
    send_bits(bits, 2, 5, -1, -1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("abort_I_out", int'(I_out), 0);
    check("abort_Q_out", int'(Q_out), 0);
    check("abort_sample_valid", int'(sample_valid), 0);
    check("abort_symbol_start", int'(symbol_start), 0);
    check("abort_queue_empty", sb.size(), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("abort_release_ready", int'(bit_ready), 1);
    bits = '{1, 0, 0, 0, 0, 0, 0, 0};
    send_bits(bits, 1, 100, -1, -1);
    wait_drain("after_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/msk_tx_pulse_gen.md
MSK_TX_PULSE_GEN -- requirements
Module: msk_tx_pulse_gen

Interface
REQ-001 The block SHALL have parameter OVERSAMPLE_FACTOR, default 20, giving samples per bit period; legal range 2..256.
REQ-002 The block SHALL have parameter AMPLITUDE, default 16383, giving the half-sine peak; legal range 1..32767.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; one output sample per cycle.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port bit_in, input, 1 bit: data bit, where 1 maps to a positive pulse and 0 to a negative pulse.
REQ-006 The block SHALL have port bit_valid, input, 1 bit: bit_in is valid.
REQ-007 The block SHALL have port bit_ready, output, 1 bit: the block accepts bit_in this cycle; transfer occurs on a clock edge where bit_valid and bit_ready are both 1.
REQ-008 The block SHALL have ports I_out and Q_out, output, signed 16 bits each: registered oversampled baseband samples.
REQ-009 The block SHALL have port sample_valid, output, 1 bit: I_out and Q_out carry a burst sample.
REQ-010 The block SHALL have port symbol_start, output, 1 bit: marks the first sample of each bit period.

Function
REQ-011 The block SHALL hold a constant ROM of 2*OVERSAMPLE_FACTOR entries, rom[n] = round(AMPLITUDE*sin(pi*n/(2*OVERSAMPLE_FACTOR))), computed at elaboration.
REQ-012 The block SHALL implement states IDLE, RUN and DRAIN, plus a phase counter cnt running 0..OVERSAMPLE_FACTOR-1 that wraps to 0.
REQ-013 In IDLE, the block SHALL drive bit_ready=1, sample_valid=0, symbol_start=0 and I_out=Q_out=0.
REQ-014 A transfer in IDLE SHALL go to RUN with cnt=0, assign the bit to channel I, and clear the channel parity.
REQ-015 In RUN, bit_ready SHALL equal 1 only when cnt=OVERSAMPLE_FACTOR-1.
REQ-016 A transfer in RUN SHALL start the accepted bit's pulse at cnt=0 of the next bit period, on the channel opposite to the previous bit (I, Q, I, ...).
REQ-017 If bit_valid=0 in RUN while cnt=OVERSAMPLE_FACTOR-1, the block SHALL go to DRAIN at the next edge.
REQ-018 In DRAIN, bit_ready SHALL be 0; the block SHALL emit the second half of the last pulse for OVERSAMPLE_FACTOR cycles, then go to IDLE.
REQ-019 Each bit's pulse SHALL span 2*OVERSAMPLE_FACTOR samples on its channel, value sign*rom[p], with p = cnt in the first bit period and p = OVERSAMPLE_FACTOR+cnt in the second.
REQ-020 A channel with no active pulse SHALL output 0 (Q during a burst's first bit period; the non-draining channel during DRAIN).
REQ-021 Negative samples SHALL be the exact two's-complement negation of rom[p]; no saturation is needed because AMPLITUDE is at most 32767.
REQ-022 Latency: the phase-0 sample of an accepted bit SHALL appear on I_out/Q_out in the cycle following the end of the bit period that accepted it; for an IDLE transfer, in the cycle immediately after the accepting edge.
REQ-023 sample_valid SHALL be 1 in every RUN and DRAIN cycle, with no gaps while bits arrive in their ready windows.
REQ-024 symbol_start SHALL be 1 exactly when sample_valid=1 and cnt=0.
REQ-025 In steady RUN, I_out^2+Q_out^2 SHALL equal AMPLITUDE^2 within rounding (constant MSK envelope).
REQ-026 A bit presented outside a ready window SHALL be held off with no loss; after DRAIN it SHALL start a new burst on channel I.

Reset
REQ-027 On reset assertion, the block SHALL immediately force state=IDLE, cnt=0, parity=I, I_out=Q_out=0, sample_valid=0 and symbol_start=0, aborting any in-flight pulse.
REQ-028 On reset release, bit_ready SHALL be 1 from the first cycle.

Verification (OVERSAMPLE_FACTOR=4, AMPLITUDE=16384; rom = 0, 6270, 11585, 15137, 16384, 15137, 11585, 6270)
REQ-029 The bench SHALL cover: single bit 1 from IDLE -> I_out = 0, 6270, 11585, 15137, 16384, 15137, 11585, 6270; Q_out = 0 throughout; sample_valid high for 8 cycles; then IDLE.
REQ-030 The bench SHALL cover: bits 1,1 with bit_valid high -> I_out as in REQ-029; Q_out = 0 for 4 cycles, then 0, 6270, ..., 6270 over 8 cycles; 12 valid samples; symbol_start every 4 cycles.
REQ-031 The bench SHALL cover: bits 0,1,0 -> I_out negated versions of the rom values for bits 1 and 3; Q_out positive; I^2+Q^2 within ±2*AMPLITUDE of 16384^2 in cycles 5-12.
REQ-032 The bench SHALL cover: 6 back-to-back bits -> bit_ready pulses exactly every 4 cycles; 28 contiguous valid samples; no DRAIN until after bit 6.
REQ-033 The bench SHALL cover: bit_valid rising one cycle after a ready window -> DRAIN of 4 samples, one IDLE cycle, then the new burst on I starting at rom[0].
REQ-034 The bench SHALL cover: reset asserted at cycle 6 of a burst -> outputs 0 and sample_valid 0 in the same cycle; bit_ready=1 after release; the next bit starts on I.
